// File: rtl/fas_pkg.sv
// Shared definitions for the FAS spectrum receive path.
//   DW   : width of one FFT bin word, {re[15:0], im[15:0]}
//   NBIN : bins per frame (fixed at 16 by the fft_frame_rx port list)
//   IW   : bin index width, log2(NBIN)
//   fft_rx_state_t : receiver FSM states
//   bin_re / bin_im : signed real / imaginary halves of a bin word
package fas_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned NBIN = 16;
    localparam int unsigned IW   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fft_rx_state_t;

    function automatic logic signed [15:0] bin_re(input logic [DW-1:0] w);
        return $signed(w[31:16]);
    endfunction

    function automatic logic signed [15:0] bin_im(input logic [DW-1:0] w);
        return $signed(w[15:0]);
    endfunction

endpackage

// File: rtl/fft_bin_mag.sv
// Combinational power of one FFT bin: mag = re*re + im*im.
//   bin_word : {re[15:0], im[15:0]}, two's complement halves
//   mag      : unsigned power; max 2*(-32768)^2 = 2^31 fits in 32 bits
module fft_bin_mag
    import fas_pkg::*;
(
    input  logic [DW-1:0] bin_word,
    output logic [DW-1:0] mag
);

    logic signed [15:0] re;
    logic signed [15:0] im;
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;

    always_comb begin
        re    = bin_re(bin_word);
        im    = bin_im(bin_word);
        re_sq = 32'(re) * 32'(re);
        im_sq = 32'(im) * 32'(im);
        // Each square is non-negative and <= 2^30, so the unsigned sum cannot wrap.
        mag   = $unsigned(re_sq) + $unsigned(im_sq);
    end

endmodule

// File: rtl/fft_frame_rx.sv
// Receiving end of the FAS spectrum interface. Captures a 16-bin frame on
// fft_valid, re-emits it serially on a valid/ready stream and reports the
// peak-power bin once per frame.
//   clk, rst          : rising-edge clock, synchronous active-low reset
//   fft_valid         : one-cycle strobe, fft_d0..fft_d15 hold a full frame
//   fft_d0..fft_d15   : bin words {re, im}
//   out_valid/ready   : stream handshake; out_data/out_idx/out_last payload
//   peak_valid        : one-cycle pulse after the bin-15 handshake
//   peak_idx/peak_mag : peak bin of the finished frame, held until next pulse
//   ovf               : sticky, a frame arrived while busy and was dropped
// Build option: define FFT_RX_MAG_EN to build the power datapath and peak
// tracking; otherwise peak_idx/peak_mag are tied to 0 and peak_valid acts
// as a frame-done strobe.
module fft_frame_rx
    import fas_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          fft_valid,
    input  logic [DW-1:0] fft_d0,
    input  logic [DW-1:0] fft_d1,
    input  logic [DW-1:0] fft_d2,
    input  logic [DW-1:0] fft_d3,
    input  logic [DW-1:0] fft_d4,
    input  logic [DW-1:0] fft_d5,
    input  logic [DW-1:0] fft_d6,
    input  logic [DW-1:0] fft_d7,
    input  logic [DW-1:0] fft_d8,
    input  logic [DW-1:0] fft_d9,
    input  logic [DW-1:0] fft_d10,
    input  logic [DW-1:0] fft_d11,
    input  logic [DW-1:0] fft_d12,
    input  logic [DW-1:0] fft_d13,
    input  logic [DW-1:0] fft_d14,
    input  logic [DW-1:0] fft_d15,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          peak_valid,
    output logic [IW-1:0] peak_idx,
    output logic [DW-1:0] peak_mag,
    output logic          ovf
);

    fft_rx_state_t state;
    fft_rx_state_t state_nxt;

    logic [DW-1:0] d_in      [NBIN];
    logic [DW-1:0] frame_buf [NBIN];
    logic [IW-1:0] cnt;

    logic hs;
    logic last_hs;
    logic capture;

    always_comb begin
        d_in[0]  = fft_d0;
        d_in[1]  = fft_d1;
        d_in[2]  = fft_d2;
        d_in[3]  = fft_d3;
        d_in[4]  = fft_d4;
        d_in[5]  = fft_d5;
        d_in[6]  = fft_d6;
        d_in[7]  = fft_d7;
        d_in[8]  = fft_d8;
        d_in[9]  = fft_d9;
        d_in[10] = fft_d10;
        d_in[11] = fft_d11;
        d_in[12] = fft_d12;
        d_in[13] = fft_d13;
        d_in[14] = fft_d14;
        d_in[15] = fft_d15;
    end

    assign hs      = out_valid & out_ready;
    assign last_hs = hs && (cnt == IW'(NBIN - 1));
    // A new frame is taken when idle, or exactly on the final handshake so
    // back-to-back frames stream without a bubble.
    assign capture = fft_valid && ((state == IDLE) || last_hs);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (fft_valid) state_nxt = SEND;
            SEND:    if (last_hs && !fft_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        if (state == SEND) begin
            out_valid = 1'b1;
            out_data  = frame_buf[cnt];
            out_idx   = cnt;
            out_last  = (cnt == IW'(NBIN - 1));
        end
    end

    // ---------------- buffer, counter, strobes ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            ovf        <= 1'b0;
            peak_valid <= 1'b0;
            for (int unsigned i = 0; i < NBIN; i++) begin
                frame_buf[i] <= '0;
            end
        end else begin
            peak_valid <= last_hs;
            if (capture) begin
                cnt <= '0;
                for (int unsigned i = 0; i < NBIN; i++) begin
                    frame_buf[i] <= d_in[i];
                end
            end else if (hs) begin
                cnt <= cnt + 1'b1;
            end
            if (fft_valid && (state == SEND) && !last_hs) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef FFT_RX_MAG_EN
    logic [DW-1:0] cur_mag;
    logic [DW-1:0] best_mag;
    logic [IW-1:0] best_idx;
    logic [DW-1:0] peak_mag_q;
    logic [IW-1:0] peak_idx_q;
    logic          mag_gt;

    fft_bin_mag u_bin_mag (
        .bin_word (out_data),
        .mag      (cur_mag)
    );

    // Strictly greater: ties keep the lower index.
    assign mag_gt = hs && (cur_mag > best_mag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            best_mag   <= '0;
            best_idx   <= '0;
            peak_mag_q <= '0;
            peak_idx_q <= '0;
        end else begin
            // The final bin is folded in here directly, since best_* is
            // cleared in the same cycle when a back-to-back frame is taken.
            if (last_hs) begin
                peak_mag_q <= mag_gt ? cur_mag : best_mag;
                peak_idx_q <= mag_gt ? cnt     : best_idx;
            end
            if (capture) begin
                best_mag <= '0;
                best_idx <= '0;
            end else if (mag_gt) begin
                best_mag <= cur_mag;
                best_idx <= cnt;
            end
        end
    end

    assign peak_mag = peak_mag_q;
    assign peak_idx = peak_idx_q;
`else
    assign peak_mag = '0;
    assign peak_idx = '0;
`endif

endmodule

// File: tb/tb_fft_frame_rx.sv
// Self-checking bench for fft_frame_rx. A frame-level model (queue of bins
// still owed to the consumer, queue of per-frame peaks) is checked against
// the DUT every cycle on the falling edge; directed literal checks pin the
// model for the key scenarios.
module tb_fft_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fft_valid = 1'b0;
    logic [31:0] d [16];
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        peak_valid;
    logic [3:0]  peak_idx;
    logic [31:0] peak_mag;
    logic        ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fft_frame_rx dut (
        .clk        (clk),
        .rst        (rst),
        .fft_valid  (fft_valid),
        .fft_d0     (d[0]),
        .fft_d1     (d[1]),
        .fft_d2     (d[2]),
        .fft_d3     (d[3]),
        .fft_d4     (d[4]),
        .fft_d5     (d[5]),
        .fft_d6     (d[6]),
        .fft_d7     (d[7]),
        .fft_d8     (d[8]),
        .fft_d9     (d[9]),
        .fft_d10    (d[10]),
        .fft_d11    (d[11]),
        .fft_d12    (d[12]),
        .fft_d13    (d[13]),
        .fft_d14    (d[14]),
        .fft_d15    (d[15]),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .peak_valid (peak_valid),
        .peak_idx   (peak_idx),
        .peak_mag   (peak_mag),
        .ovf        (ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
    } bin_t;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] mag;
    } pk_t;

    bin_t        exp_q[$];
    pk_t         pk_q[$];
    logic        pend_peak  = 1'b0;
    logic        exp_ovf    = 1'b0;
    logic [3:0]  exp_pk_idx = '0;
    logic [31:0] exp_pk_mag = '0;
    logic        checking   = 1'b0;
    int          peaks_seen = 0;
    int          peak_cyc   = 0;
    logic [3:0]  seen_pk_idx;
    logic [31:0] seen_pk_mag;

    function automatic pk_t frame_peak();
        pk_t    p;
        longint best = 0;
        int     bi   = 0;
        for (int k = 0; k < 16; k++) begin
            longint re = $signed(d[k][31:16]);
            longint im = $signed(d[k][15:0]);
            longint m  = re * re + im * im;
            if (m > best) begin
                best = m;
                bi   = k;
            end
        end
`ifdef FFT_RX_MAG_EN
        p.idx = 4'(bi);
        p.mag = 32'(best);
`else
        p.idx = '0;
        p.mag = '0;
`endif
        return p;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("ovf", ovf, exp_ovf);
            chk("peak_valid", peak_valid, pend_peak);
            if (pend_peak && pk_q.size() > 0) begin
                exp_pk_idx = pk_q[0].idx;
                exp_pk_mag = pk_q[0].mag;
                void'(pk_q.pop_front());
            end
            if (peak_valid) begin
                peaks_seen++;
                peak_cyc    = cyc;
                seen_pk_idx = peak_idx;
                seen_pk_mag = peak_mag;
            end
            pend_peak = 1'b0;
            chk("peak_idx", peak_idx, exp_pk_idx);
            chk("peak_mag", peak_mag, exp_pk_mag);

            chk("out_valid", out_valid, exp_q.size() > 0);
            if (out_valid && exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q[0].data);
                chk("out_idx", out_idx, exp_q[0].idx);
                chk("out_last", out_last, exp_q[0].idx == 4'd15);
                if (out_ready) begin
                    if (exp_q[0].idx == 4'd15) pend_peak = 1'b1;
                    void'(exp_q.pop_front());
                end
            end

            if (fft_valid) begin
                if (exp_q.size() == 0) begin
                    for (int k = 0; k < 16; k++) exp_q.push_back('{d[k], 4'(k)});
                    pk_q.push_back(frame_peak());
                end else begin
                    exp_ovf = 1'b1;
                end
            end

            if (!rst) begin
                exp_q.delete();
                pk_q.delete();
                pend_peak  = 1'b0;
                exp_ovf    = 1'b0;
                exp_pk_idx = '0;
                exp_pk_mag = '0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wd(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction

    task automatic set_frame(input int kind);
        for (int k = 0; k < 16; k++) begin
            case (kind)
                0: d[k] = wd(k, -k);
                1: d[k] = wd(100 - 7 * k, 13 * k - 50);
                2: d[k] = wd(k * k, 5);
                3: d[k] = wd(32767 - k, 1234);
                4: d[k] = wd(-3 * k, k);
                5: d[k] = wd(k + 1000, 20 - k);
                6: d[k] = (k == 3 || k == 9) ? 32'h8000_8000 : 32'h0;
                default: d[k] = 32'h0;
            endcase
        end
    endtask

    task automatic wait_peaks(input string name, input int target, input int budget);
        int n = 0;
        while (peaks_seen < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, peaks_seen >= target, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int t0;
        int base;
        for (int k = 0; k < 16; k++) d[k] = '0;

        rst = 1'b0;
        tick();
        checking = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_peak_valid", peak_valid, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // 1: ramp frame, consumer always ready
        set_frame(0);
        out_ready = 1'b1;
        fft_valid = 1'b1;
        t0 = cyc;
        tick();
        fft_valid = 1'b0;
        wait_peaks("t1_done", 1, 40);
        chk("t1_peak_latency", peak_cyc - t0, 17);
`ifdef FFT_RX_MAG_EN
        chk("t1_peak_idx", seen_pk_idx, 4'd15);
        chk("t1_peak_mag", seen_pk_mag, 32'd450);
`else
        chk("t1_peak_idx", seen_pk_idx, 4'd0);
        chk("t1_peak_mag", seen_pk_mag, 32'd0);
`endif
        repeat (3) tick();
        chk("t1_single_peak", peaks_seen, 1);

        // 2: stalling consumer, ready pattern 1,0,0 repeating
        set_frame(1);
        fft_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        fft_valid = 1'b0;
        begin
            int n = 0;
            while (peaks_seen < 2 && n < 100) begin
                out_ready = (n % 3 == 0);
                tick();
                n++;
            end
            chk("t2_done", peaks_seen >= 2, 1'b1);
        end
        out_ready = 1'b1;

        // 3: second frame arrives while stalled at bin 5 -> dropped, ovf
        set_frame(2);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        repeat (5) tick();
        out_ready = 1'b0;
        set_frame(3);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t3_ovf", ovf, 1'b1);
        chk("t3_stalled_idx", out_idx, 4'd5);
        tick();
        out_ready = 1'b1;
        wait_peaks("t3_done", 3, 40);
        repeat (4) tick();
        chk("t3_single_peak", peaks_seen, 3);
        chk("t3_idle", out_valid, 1'b0);

        do_reset();
        tick();

        // 4: back-to-back frame on the bin-15 handshake
        set_frame(4);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        repeat (15) tick();
        set_frame(5);
        fft_valid = 1'b1;
        base = peaks_seen;
        tick();
        fft_valid = 1'b0;
        @(negedge clk);
        chk("t4_peak_valid", peak_valid, 1'b1);
        chk("t4_out_valid", out_valid, 1'b1);
        chk("t4_out_idx", out_idx, 4'd0);
        chk("t4_out_data", out_data, wd(1000, 20));
        chk("t4_ovf", ovf, 1'b0);
        wait_peaks("t4_done", base + 2, 40);

        // 5: extreme values and the tie rule, then an all-zero frame
        set_frame(6);
        fft_valid = 1'b1;
        base = peaks_seen;
        tick();
        fft_valid = 1'b0;
        wait_peaks("t5_done", base + 1, 40);
`ifdef FFT_RX_MAG_EN
        chk("t5_peak_idx", seen_pk_idx, 4'd3);
        chk("t5_peak_mag", seen_pk_mag, 32'h8000_0000);
`else
        chk("t5_peak_idx", seen_pk_idx, 4'd0);
        chk("t5_peak_mag", seen_pk_mag, 32'h0);
`endif
        set_frame(7);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        wait_peaks("t5z_done", base + 2, 40);
        chk("t5z_peak_idx", seen_pk_idx, 4'd0);
        chk("t5z_peak_mag", seen_pk_mag, 32'h0);

        // 6: reset while bin 7 is on the output
        set_frame(1);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        repeat (7) tick();
        base = peaks_seen;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_out_data", out_data, 32'h0);
        chk("t6_out_idx", out_idx, 4'd0);
        chk("t6_out_last", out_last, 1'b0);
        chk("t6_peak_valid", peak_valid, 1'b0);
        chk("t6_peak_mag", peak_mag, 32'h0);
        repeat (20) tick();
        chk("t6_no_peak", peaks_seen, base);
        set_frame(0);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        wait_peaks("t6_fresh_done", base + 1, 40);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
